// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit for the 8-bit accumulator CPU.
// A state register steps through fetch, decode and execute.
// Datapath controls are decoded from the current state.
// In BRZ_5 the decode also uses the Z flag from CCR_Result.
module cpu_control_unit (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] IR,
   input  logic [3:0] CCR_Result,
   output logic       IR_Load,
   output logic       MAR_Load,
   output logic       PC_Load,
   output logic       PC_Inc,
   output logic       A_Load,
   output logic       B_Load,
   output logic       CCR_Load,
   output logic [2:0] ALU_Sel,
   output logic [1:0] Bus1_Sel,
   output logic [1:0] Bus2_Sel,
   output logic       write
);

   typedef enum logic [5:0] {
      FETCH_0, FETCH_1, FETCH_2, DECODE_3,
      LDA_IMM_4, LDA_IMM_5, LDA_IMM_6,
      LDA_DIR_4, LDA_DIR_5, LDA_DIR_6, LDA_DIR_7, LDA_DIR_8,
      STA_DIR_4, STA_DIR_5, STA_DIR_6, STA_DIR_7,
      LDB_IMM_4, LDB_IMM_5, LDB_IMM_6,
      LDB_DIR_4, LDB_DIR_5, LDB_DIR_6, LDB_DIR_7, LDB_DIR_8,
      STB_DIR_4, STB_DIR_5, STB_DIR_6, STB_DIR_7,
      ADD_IMM_4, ADD_IMM_5, ADD_IMM_6, ADD_IMM_7,
      ADD_AB_4, SUB_AB_4, AND_AB_4, OR_AB_4,
      BRA_4, BRA_5, BRA_6,
      BRZ_4, BRZ_5, BRZ_6,
      HALT
   } state_t;

   state_t r_state;

   // State sequencing: reset aborts any instruction, decode dispatches on IR
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= FETCH_0;
      end else begin
         case (r_state)
            FETCH_0:   r_state <= FETCH_1;
            FETCH_1:   r_state <= FETCH_2;
            FETCH_2:   r_state <= DECODE_3;
            DECODE_3: begin
               case (IR)
                  8'h01:   r_state <= LDA_IMM_4;
                  8'h02:   r_state <= LDA_DIR_4;
                  8'h03:   r_state <= STA_DIR_4;
                  8'h04:   r_state <= LDB_IMM_4;
                  8'h05:   r_state <= LDB_DIR_4;
                  8'h06:   r_state <= STB_DIR_4;
                  8'h11:   r_state <= ADD_IMM_4;
                  8'h42:   r_state <= ADD_AB_4;
                  8'h43:   r_state <= SUB_AB_4;
                  8'h44:   r_state <= AND_AB_4;
                  8'h45:   r_state <= OR_AB_4;
                  8'h20:   r_state <= BRA_4;
                  8'h30:   r_state <= BRZ_4;
                  8'hFF:   r_state <= HALT;
                  default: r_state <= FETCH_0;
               endcase
            end
            LDA_IMM_4: r_state <= LDA_IMM_5;
            LDA_IMM_5: r_state <= LDA_IMM_6;
            LDA_DIR_4: r_state <= LDA_DIR_5;
            LDA_DIR_5: r_state <= LDA_DIR_6;
            LDA_DIR_6: r_state <= LDA_DIR_7;
            LDA_DIR_7: r_state <= LDA_DIR_8;
            STA_DIR_4: r_state <= STA_DIR_5;
            STA_DIR_5: r_state <= STA_DIR_6;
            STA_DIR_6: r_state <= STA_DIR_7;
            LDB_IMM_4: r_state <= LDB_IMM_5;
            LDB_IMM_5: r_state <= LDB_IMM_6;
            LDB_DIR_4: r_state <= LDB_DIR_5;
            LDB_DIR_5: r_state <= LDB_DIR_6;
            LDB_DIR_6: r_state <= LDB_DIR_7;
            LDB_DIR_7: r_state <= LDB_DIR_8;
            STB_DIR_4: r_state <= STB_DIR_5;
            STB_DIR_5: r_state <= STB_DIR_6;
            STB_DIR_6: r_state <= STB_DIR_7;
            ADD_IMM_4: r_state <= ADD_IMM_5;
            ADD_IMM_5: r_state <= ADD_IMM_6;
            ADD_IMM_6: r_state <= ADD_IMM_7;
            BRA_4:     r_state <= BRA_5;
            BRA_5:     r_state <= BRA_6;
            BRZ_4:     r_state <= BRZ_5;
            BRZ_5: begin
               if (CCR_Result[2]) begin
                  r_state <= BRZ_6;
               end else begin
                  r_state <= FETCH_0;
               end
            end
            HALT:      r_state <= HALT;
            default:   r_state <= FETCH_0;
         endcase
      end
   end

   // Control decode: every output starts at its idle value, and each state sets only what it changes
   always_comb begin
      IR_Load  = 1'b0;
      MAR_Load = 1'b0;
      PC_Load  = 1'b0;
      PC_Inc   = 1'b0;
      A_Load   = 1'b0;
      B_Load   = 1'b0;
      CCR_Load = 1'b0;
      ALU_Sel  = 3'b000;
      Bus1_Sel = 2'b00;
      Bus2_Sel = 2'b00;
      write    = 1'b0;
      case (r_state)
         FETCH_0, LDA_IMM_4, LDA_DIR_4, STA_DIR_4, LDB_IMM_4, LDB_DIR_4,
         STB_DIR_4, ADD_IMM_4, BRA_4, BRZ_4: begin
            Bus1_Sel = 2'b00;
            Bus2_Sel = 2'b01;
            MAR_Load = 1'b1;
         end
         FETCH_1, LDA_IMM_5, LDA_DIR_5, STA_DIR_5, LDB_IMM_5, LDB_DIR_5,
         STB_DIR_5, ADD_IMM_5: begin
            PC_Inc = 1'b1;
         end
         FETCH_2: begin
            Bus2_Sel = 2'b10;
            IR_Load  = 1'b1;
         end
         LDA_IMM_6, LDA_DIR_8: begin
            Bus2_Sel = 2'b10;
            A_Load   = 1'b1;
         end
         LDB_IMM_6, LDB_DIR_8, ADD_IMM_6: begin
            Bus2_Sel = 2'b10;
            B_Load   = 1'b1;
         end
         LDA_DIR_6, STA_DIR_6, LDB_DIR_6, STB_DIR_6: begin
            Bus2_Sel = 2'b10;
            MAR_Load = 1'b1;
         end
         STA_DIR_7: begin
            Bus1_Sel = 2'b01;
            write    = 1'b1;
         end
         STB_DIR_7: begin
            Bus1_Sel = 2'b10;
            write    = 1'b1;
         end
         ADD_IMM_7, ADD_AB_4, SUB_AB_4, AND_AB_4, OR_AB_4: begin
            Bus1_Sel = 2'b10;
            Bus2_Sel = 2'b00;
            A_Load   = 1'b1;
            CCR_Load = 1'b1;
            case (r_state)
               SUB_AB_4: ALU_Sel = 3'b001;
               AND_AB_4: ALU_Sel = 3'b010;
               OR_AB_4:  ALU_Sel = 3'b011;
               default:  ALU_Sel = 3'b000;
            endcase
         end
         BRZ_5: begin
            // Z clear: step PC past the branch target operand
            if (CCR_Result[2]) begin
               PC_Inc = 1'b0;
            end else begin
               PC_Inc = 1'b1;
            end
         end
         BRA_6, BRZ_6: begin
            Bus2_Sel = 2'b10;
            PC_Load  = 1'b1;
         end
         default: begin
            PC_Inc = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed-vector bench for cpu_control_unit. The bench drives IR and CCR_Result directly.
// Each cycle it checks the packed control word against a hand-written constant.
module tb_cpu_control_unit;

   logic       Clk;
   logic       Reset;
   logic [7:0] IR;
   logic [3:0] CCR_Result;
   logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
   logic [2:0] ALU_Sel;
   logic [1:0] Bus1_Sel, Bus2_Sel;

   int tests_run_s;
   int tests_failed_s;

   // Packed word: IR_Load MAR_Load PC_Load PC_Inc A_Load B_Load CCR_Load ALU[3] Bus1[2] Bus2[2] write
   localparam logic [14:0] C_NONE = 15'b0_0_0_0_0_0_0_000_00_00_0;
   localparam logic [14:0] C_F0   = 15'b0_1_0_0_0_0_0_000_00_01_0;
   localparam logic [14:0] C_INC  = 15'b0_0_0_1_0_0_0_000_00_00_0;
   localparam logic [14:0] C_F2   = 15'b1_0_0_0_0_0_0_000_00_10_0;
   localparam logic [14:0] C_LDA  = 15'b0_0_0_0_1_0_0_000_00_10_0;
   localparam logic [14:0] C_LDB  = 15'b0_0_0_0_0_1_0_000_00_10_0;
   localparam logic [14:0] C_MARM = 15'b0_1_0_0_0_0_0_000_00_10_0;
   localparam logic [14:0] C_STA  = 15'b0_0_0_0_0_0_0_000_01_00_1;
   localparam logic [14:0] C_STB  = 15'b0_0_0_0_0_0_0_000_10_00_1;
   localparam logic [14:0] C_ADD  = 15'b0_0_0_0_1_0_1_000_10_00_0;
   localparam logic [14:0] C_SUB  = 15'b0_0_0_0_1_0_1_001_10_00_0;
   localparam logic [14:0] C_AND  = 15'b0_0_0_0_1_0_1_010_10_00_0;
   localparam logic [14:0] C_OR   = 15'b0_0_0_0_1_0_1_011_10_00_0;
   localparam logic [14:0] C_PCL  = 15'b0_0_1_0_0_0_0_000_00_10_0;

   cpu_control_unit dut (
      .Clk(Clk), .Reset(Reset), .IR(IR), .CCR_Result(CCR_Result),
      .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
      .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel),
      .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic logic [14:0] ctl_word();
      return {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
              ALU_Sel, Bus1_Sel, Bus2_Sel, write};
   endfunction

   task automatic check_val(input string tag, input logic [14:0] obs, input logic [14:0] exp);
      tests_run_s++;
      if (obs !== exp) begin
         tests_failed_s++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // Check the current state's outputs, then advance to the next sample point (one cycle later)
   task automatic cyc(input string tag, input logic [14:0] exp);
      check_val(tag, ctl_word(), exp);
      @(negedge Clk);
      #1;
   endtask

   task automatic fetch(input string tag, input logic [7:0] op);
      IR = op;
      cyc({tag, "_f0"}, C_F0);
      cyc({tag, "_f1"}, C_INC);
      cyc({tag, "_f2"}, C_F2);
      cyc({tag, "_dec"}, C_NONE);
   endtask

   initial begin
      tests_run_s    = 0;
      tests_failed_s = 0;
      Reset      = 1'b0;
      IR         = 8'hFF;
      CCR_Result = 4'b0000;
      repeat (2) @(negedge Clk);
      check_val("rst_hold", ctl_word(), C_F0);
      Reset = 1'b1;
      #1;
      // IR = FF: the full fetch must run before the unit halts
      fetch("halt", 8'hFF);
      for (int i = 0; i < 4; i++) cyc("halt_idle", C_NONE);
      IR = 8'h01;
      CCR_Result = 4'b1111;
      for (int i = 0; i < 3; i++) cyc("halt_ir_chg", C_NONE);
      // Asynchronous reset out of HALT, asserted mid-cycle
      #2;
      Reset = 1'b0;
      #1;
      check_val("halt_async_rst", ctl_word(), C_F0);
      @(negedge Clk);
      check_val("rst_held", ctl_word(), C_F0);
      Reset = 1'b1;
      CCR_Result = 4'b0000;
      #1;

      // LDA_IMM 01 AA: A_Load in cycle 7
      fetch("lda_imm", 8'h01);
      cyc("lda_imm_s4", C_F0);
      cyc("lda_imm_s5", C_INC);
      cyc("lda_imm_s6", C_LDA);
      // ADD_IMM 11 05
      fetch("add_imm", 8'h11);
      cyc("add_imm_s4", C_F0);
      cyc("add_imm_s5", C_INC);
      cyc("add_imm_s6", C_LDB);
      cyc("add_imm_s7", C_ADD);
      // STA_DIR 03 50: write for exactly one cycle, then a fresh fetch
      fetch("sta", 8'h03);
      cyc("sta_s4", C_F0);
      cyc("sta_s5", C_INC);
      cyc("sta_s6", C_MARM);
      cyc("sta_s7", C_STA);
      // LDA_DIR with its read-latency idle state
      fetch("lda_dir", 8'h02);
      cyc("lda_dir_s4", C_F0);
      cyc("lda_dir_s5", C_INC);
      cyc("lda_dir_s6", C_MARM);
      cyc("lda_dir_s7", C_NONE);
      cyc("lda_dir_s8", C_LDA);
      // LDB_IMM, LDB_DIR, STB_DIR
      fetch("ldb_imm", 8'h04);
      cyc("ldb_imm_s4", C_F0);
      cyc("ldb_imm_s5", C_INC);
      cyc("ldb_imm_s6", C_LDB);
      fetch("ldb_dir", 8'h05);
      cyc("ldb_dir_s4", C_F0);
      cyc("ldb_dir_s5", C_INC);
      cyc("ldb_dir_s6", C_MARM);
      cyc("ldb_dir_s7", C_NONE);
      cyc("ldb_dir_s8", C_LDB);
      fetch("stb", 8'h06);
      cyc("stb_s4", C_F0);
      cyc("stb_s5", C_INC);
      cyc("stb_s6", C_MARM);
      cyc("stb_s7", C_STB);
      // Register-register ALU ops
      fetch("add_ab", 8'h42);
      cyc("add_ab_s4", C_ADD);
      fetch("sub_ab", 8'h43);
      cyc("sub_ab_s4", C_SUB);
      fetch("and_ab", 8'h44);
      cyc("and_ab_s4", C_AND);
      fetch("or_ab", 8'h45);
      cyc("or_ab_s4", C_OR);
      // Unknown opcode is a NOP
      fetch("nop", 8'h77);
      // BRA
      fetch("bra", 8'h20);
      cyc("bra_s4", C_F0);
      cyc("bra_s5", C_NONE);
      cyc("bra_s6", C_PCL);
      // BRZ taken, Z = 1
      CCR_Result = 4'b0100;
      fetch("brz_t", 8'h30);
      cyc("brz_t_s4", C_F0);
      cyc("brz_t_s5", C_NONE);
      cyc("brz_t_s6", C_PCL);
      // BRZ not taken, Z = 0
      CCR_Result = 4'b0000;
      fetch("brz_n", 8'h30);
      cyc("brz_n_s4", C_F0);
      cyc("brz_n_s5", C_INC);
      // BRZ not taken with N, V and C set but Z clear
      CCR_Result = 4'b1011;
      fetch("brz_nvc", 8'h30);
      cyc("brz_nvc_s4", C_F0);
      cyc("brz_nvc_s5", C_INC);
      CCR_Result = 4'b0000;
      // Reset in the middle of STA aborts it
      fetch("sta_abort", 8'h03);
      cyc("sta_abort_s4", C_F0);
      cyc("sta_abort_s5", C_INC);
      check_val("sta_abort_s6", ctl_word(), C_MARM);
      Reset = 1'b0;
      #1;
      check_val("sta_async_rst", ctl_word(), C_F0);
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      fetch("after_abort", 8'h01);
      cyc("after_abort_s4", C_F0);
      cyc("after_abort_s5", C_INC);
      cyc("after_abort_s6", C_LDA);
      // Final halt with inputs wiggling
      fetch("end", 8'hFF);
      for (int i = 0; i < 6; i++) begin
         IR = 8'(i * 37);
         CCR_Result = 4'(i);
         cyc("end_idle", C_NONE);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run_s, tests_failed_s);
      $finish;
   end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Multi-cycle FSM control unit for the team's 8-bit accumulator CPU (registers PC, IR, MAR, A, B, CCR; ALU; two-bus datapath; synchronous memory).
- Sequences fetch, decode and execute.
- Drives register load enables, bus selects, the ALU operation and the memory write strobe from the current state, IR and CCR flags.

Parameters:
- none. Opcodes are fixed local constants; addresses are one byte.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- IR  input  8  current instruction register contents (opcode).
- CCR_Result  input  4  flags NZVC: [3]=N, [2]=Z, [1]=V, [0]=C.
- IR_Load  output  1  load IR from Bus2.
- MAR_Load  output  1  load MAR from Bus2.
- PC_Load  output  1  load PC from Bus2.
- PC_Inc  output  1  PC <= PC+1.
- A_Load  output  1  load A from Bus2.
- B_Load  output  1  load B from Bus2.
- CCR_Load  output  1  load CCR from ALU flags.
- ALU_Sel  output  3  000 ADD, 001 SUB, 010 AND, 011 OR.
- Bus1_Sel  output  2  00 PC, 01 A, 10 B, 11 unused.
- Bus2_Sel  output  2  00 ALU result, 01 Bus1, 10 memory data, 11 unused.
- write  output  1  memory write strobe (address = MAR, data = Bus1).

Behaviour:
- Interface: one clock (Clk); Reset is asynchronous and active-low.
- State register updates on rising Clk. Reset low forces state FETCH_0 immediately and holds it.
- Outputs are decoded combinationally from state, plus CCR_Result in BRZ_5.
- Default in every state: all load/inc/write = 0, ALU_Sel = 000, Bus1_Sel = 00, Bus2_Sel = 00. Each state lists only deviations.
- During reset, outputs equal the FETCH_0 decode.
- Memory read latency: data for an address loaded into MAR is valid on Bus2 (sel 10) two states after the MAR_Load state.
- FETCH_0: Bus1 = PC, Bus2 = Bus1, MAR_Load.
- FETCH_1: PC_Inc.
- FETCH_2: Bus2 = memory, IR_Load.
- DECODE_3: no outputs. Next state from IR:
  - 0x01 LDA_IMM, 0x02 LDA_DIR, 0x03 STA_DIR
  - 0x04 LDB_IMM, 0x05 LDB_DIR, 0x06 STB_DIR
  - 0x11 ADD_IMM
  - 0x42 ADD_AB, 0x43 SUB_AB, 0x44 AND_AB, 0x45 OR_AB
  - 0x20 BRA, 0x30 BRZ_DIR
  - 0xFF END
  - any other opcode: NOP, return to FETCH_0.
- Operand prefix (all operand instructions): S4 = MAR <= PC (as FETCH_0); S5 = PC_Inc.
- LDx_IMM: S6 Bus2 = memory, A_Load (LDA) or B_Load (LDB) -> FETCH_0. Total 7 cycles.
- LDx_DIR:
  - S6 Bus2 = memory, MAR_Load.
  - S7 idle (read latency).
  - S8 Bus2 = memory, A_Load/B_Load -> FETCH_0.
- STx_DIR:
  - S6 Bus2 = memory, MAR_Load.
  - S7 Bus1 = A (STA) or B (STB), write = 1 -> FETCH_0.
- ADD_IMM:
  - S6 Bus2 = memory, B_Load.
  - S7 Bus1 = B, Bus2 = ALU, ALU_Sel = 000, A_Load, CCR_Load -> FETCH_0.
  - B is overwritten by the immediate (documented side effect).
- ALU_AB ops: single execute state S4: Bus1 = B, Bus2 = ALU, ALU_Sel per opcode, A_Load, CCR_Load -> FETCH_0.
- BRA: S4 MAR <= PC; S5 idle; S6 Bus2 = memory, PC_Load -> FETCH_0.
- BRZ_DIR:
  - S4 MAR <= PC.
  - S5: if CCR_Result[2] = 1, no outputs, go to S6; else PC_Inc (skip operand), go to FETCH_0.
  - S6 Bus2 = memory, PC_Load -> FETCH_0.
  - Z is sampled only in BRZ_5.
- END: HALT state. All outputs default; stays in HALT until Reset. IR changes are ignored.
- Never assert PC_Load and PC_Inc together. Never assert write with any load.
- Reset mid-instruction aborts it; the next cycle after release is FETCH_0.

Test Plan:
- Reset low then high with IR = 0xFF -> first cycles FETCH_0 (MAR_Load = 1, Bus2_Sel = 01), FETCH_1 (PC_Inc = 1), FETCH_2 (IR_Load = 1, Bus2_Sel = 10). No HALT before decode.
- Memory 0x00: 01 AA -> A_Load = 1 with Bus2_Sel = 10 exactly in cycle 7. PC_Inc pulses twice. Next cycle is FETCH_0.
- Program 01 AA, 11 05 -> ADD_IMM asserts B_Load, then A_Load + CCR_Load with ALU_Sel = 000, Bus1_Sel = 10, Bus2_Sel = 00.
- STA_DIR 03 50 -> MAR_Load twice (from PC, then from memory), then write = 1 with Bus1_Sel = 01 for exactly one cycle.
- BRZ_DIR 30 80 with CCR_Result = 0100 -> PC_Load = 1 in S6, PC_Inc not asserted in S5. With CCR_Result = 0000 -> PC_Inc in S5, no PC_Load.
- Opcode 0xFF -> all outputs 0 indefinitely. Asserting Reset low mid-HALT or mid-STA returns to FETCH_0 asynchronously.
